// File: rtl/hyst_control.sv
// hyst_control: heat/cool hysteresis controller with min-on hold, lockout and config fault detection
//   params : W (word width), MIN_ON (valid samples held before exit), LOCKOUT (cycles held off after exit)
//   inputs : clk, rst (async, active-low), enable, sample_valid, temp, hi_th, lo_th, hyst
//   outputs: heat_out, cool_out, busy, fault, state_o (0 IDLE, 1 HEAT, 2 COOL, 3 LOCKOUT)
//   option : HYST_DEBOUNCE_EN requires two consecutive matching samples to leave IDLE
module hyst_control #(
  parameter int W = 8,
  parameter int MIN_ON = 2,
  parameter int LOCKOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         sample_valid,
  input  logic [W-1:0] temp,
  input  logic [W-1:0] hi_th,
  input  logic [W-1:0] lo_th,
  input  logic [W-1:0] hyst,
  output logic         heat_out,
  output logic         cool_out,
  output logic         busy,
  output logic         fault,
  output logic [1:0]   state_o
);
  typedef enum logic [1:0] {IDLE, HEAT, COOL, LOCK} state_t;
  state_t state;
  logic [7:0] on_cnt;
  logic [15:0] lock_cnt;
  logic [W:0] sum, dif;
  logic [W-1:0] heat_exit, cool_exit;
  logic [7:0] on_nxt;
  logic min_ok, go_cool, go_heat;
  localparam logic [15:0] LOCK_LD = 16'(LOCKOUT - 1);
`ifdef HYST_DEBOUNCE_EN
  logic pend, pend_dir;
`endif
  // Exit thresholds saturate rather than wrap.
  assign sum = {1'b0, lo_th} + {1'b0, hyst};
  assign dif = {1'b0, hi_th} - {1'b0, hyst};
  assign heat_exit = sum[W] ? '1 : sum[W-1:0];
  assign cool_exit = dif[W] ? '0 : dif[W-1:0];
  // on_nxt is k, the index of the current valid sample since entry.
  assign on_nxt = on_cnt == 8'hFF ? on_cnt : on_cnt + 8'd1;
  assign min_ok = on_nxt >= 8'(MIN_ON);
  assign go_cool = sample_valid && !fault && temp >= hi_th;
  assign go_heat = sample_valid && !fault && temp <= lo_th;
  assign heat_out = state == HEAT;
  assign cool_out = state == COOL;
  assign busy = state != IDLE;
  assign state_o = state;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      on_cnt <= '0;
      lock_cnt <= '0;
      fault <= 1'b0;
`ifdef HYST_DEBOUNCE_EN
      pend <= 1'b0;
      pend_dir <= 1'b0;
`endif
    end else begin
      fault <= lo_th >= hi_th;
      if (!enable) begin
        state <= IDLE;
        on_cnt <= '0;
        lock_cnt <= '0;
`ifdef HYST_DEBOUNCE_EN
        pend <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            on_cnt <= '0;
`ifdef HYST_DEBOUNCE_EN
            if (fault) pend <= 1'b0;
            else if (sample_valid) begin
              if (go_cool || go_heat) begin
                if (pend && pend_dir == go_cool) begin
                  state <= go_cool ? COOL : HEAT;
                  pend <= 1'b0;
                end else begin
                  pend <= 1'b1;
                  pend_dir <= go_cool;
                end
              end else pend <= 1'b0;
            end
`else
            if (go_cool) state <= COOL;
            else if (go_heat) state <= HEAT;
`endif
          end
          HEAT, COOL: begin
            if (fault) begin
              state <= LOCK;
              lock_cnt <= LOCK_LD;
            end else if (sample_valid) begin
              on_cnt <= on_nxt;
              if (min_ok && (state == HEAT ? temp >= heat_exit : temp <= cool_exit)) begin
                state <= LOCK;
                lock_cnt <= LOCK_LD;
              end
            end
          end
          default: begin
            if (lock_cnt == '0) state <= IDLE;
            else lock_cnt <= lock_cnt - 16'd1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hyst_control.sv
// tb_hyst_control: directed scoreboard bench for hyst_control
module tb_hyst_control;
  logic clk = 0, rst = 0, enable = 1, sample_valid = 0, chk = 0;
  logic [7:0] temp = 0, hi_th = 90, lo_th = 70, hyst = 5;
  logic heat_out, cool_out, busy, fault;
  logic [1:0] state_o;
  logic [2:0] exp_q[$];
  logic [2:0] e;
  logic [6:0] want, got;
  int checks = 0, errors = 0;
  localparam logic [1:0] S_IDLE = 0, S_HEAT = 1, S_COOL = 2, S_LOCK = 3;
  hyst_control #(.W(8), .MIN_ON(2), .LOCKOUT(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid), .temp(temp),
    .hi_th(hi_th), .lo_th(lo_th), .hyst(hyst), .heat_out(heat_out), .cool_out(cool_out),
    .busy(busy), .fault(fault), .state_o(state_o)
  );
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    if (chk) begin
      #2;
      checks++;
      got = {fault, busy, cool_out, heat_out, state_o};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got %b, no expectation queued", got);
      end else begin
        e = exp_q.pop_front();
        want = {e[2], e[1:0] != S_IDLE, e[1:0] == S_COOL, e[1:0] == S_HEAT, e[1:0]};
        if (got !== want) begin
          errors++;
          $display("FAIL t=%0t {fault,busy,cool,heat,state}: got %b want %b", $time, got, want);
        end
      end
    end
  end
  task automatic cyc(input logic v, input logic [7:0] t, input logic [1:0] es, input logic ef = 0);
    sample_valid = v;
    temp = t;
    chk = 1;
    exp_q.push_back({ef, es});
    @(negedge clk);
    sample_valid = 0;
    chk = 0;
  endtask
  task automatic enter(input logic [7:0] t, input logic [1:0] es);
`ifdef HYST_DEBOUNCE_EN
    cyc(1, t, S_IDLE);
`endif
    cyc(1, t, es);
  endtask
  task automatic lockout_rest(input logic ef = 0);
    for (int i = 0; i < 7; i++) cyc(i == 3, 8'd95, S_LOCK, ef);
    cyc(0, 0, S_IDLE, ef);
  endtask
  initial begin
    @(negedge clk);
    cyc(0, 0, S_IDLE);
    cyc(1, 95, S_IDLE);
    rst = 1;
    enter(95, S_COOL);
    cyc(1, 80, S_COOL);
    cyc(0, 20, S_COOL);
    cyc(1, 84, S_LOCK);
    lockout_rest();
    enter(65, S_HEAT);
    cyc(1, 74, S_HEAT);
    cyc(0, 200, S_HEAT);
    cyc(1, 74, S_HEAT);
    cyc(1, 76, S_LOCK);
    lockout_rest();
    lo_th = 250; hi_th = 255; hyst = 20;
    enter(250, S_HEAT);
    cyc(1, 254, S_HEAT);
    cyc(1, 254, S_HEAT);
    cyc(1, 255, S_LOCK);
    lockout_rest();
    lo_th = 5; hi_th = 10; hyst = 20;
    enter(200, S_COOL);
    cyc(1, 1, S_COOL);
    cyc(1, 1, S_COOL);
    cyc(1, 0, S_LOCK);
    lockout_rest();
    lo_th = 70; hi_th = 90; hyst = 5;
    enter(65, S_HEAT);
    lo_th = 90;
    cyc(0, 0, S_HEAT, 1);
    cyc(0, 0, S_LOCK, 1);
    lockout_rest(1);
    cyc(1, 50, S_IDLE, 1);
    cyc(1, 50, S_IDLE, 1);
    lo_th = 70;
    cyc(0, 0, S_IDLE);
    enter(95, S_COOL);
    enable = 0;
    cyc(0, 0, S_IDLE);
    cyc(1, 95, S_IDLE);
    enable = 1;
    cyc(0, 0, S_IDLE);
`ifdef HYST_DEBOUNCE_EN
    cyc(1, 95, S_IDLE);
    cyc(1, 85, S_IDLE);
    cyc(1, 95, S_IDLE);
    cyc(1, 95, S_COOL);
`else
    cyc(1, 85, S_IDLE);
    cyc(1, 95, S_COOL);
`endif
    #2 rst = 0;
    cyc(1, 60, S_IDLE);
    rst = 1;
    enter(60, S_HEAT);
    cyc(1, 80, S_HEAT);
    cyc(1, 80, S_LOCK);
    cyc(0, 0, S_LOCK);
    #2 rst = 0;
    cyc(0, 0, S_IDLE);
    rst = 1;
    cyc(0, 0, S_IDLE);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hyst_control.md
Name: hyst_control

Overview:
- Parametrised successor to the single-output temperature controller.
- Drives separate heat and cool outputs from a sampled temperature word.
- Thresholds and hysteresis are run-time programmable, with minimum-on and lockout timing to prevent short-cycling.
- Sits between the sensor sampling front end (valid-strobed samples) and the actuator drivers.

Parameters:
W, 8, width of temperature, threshold and hysteresis words (unsigned)
MIN_ON, 2, minimum valid samples an active state is held before exit is permitted (1..255)
LOCKOUT, 8, clock cycles outputs are held off after an active state ends (1..65535)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted low)
enable  input  1  controller enable; 0 forces outputs off
sample_valid  input  1  one-cycle strobe; temp is valid this cycle
temp  input  W  measured temperature, unsigned
hi_th  input  W  cool-entry threshold
lo_th  input  W  heat-entry threshold
hyst  input  W  hysteresis band
heat_out  output  1  heater drive
cool_out  output  1  cooler drive
busy  output  1  high in HEAT, COOL or LOCKOUT
fault  output  1  configuration error (lo_th >= hi_th)
state_o  output  2  current state: 0 IDLE, 1 HEAT, 2 COOL, 3 LOCKOUT

Behaviour:
- Reset (rst low, async): state IDLE, counters 0, heat_out=0, cool_out=0, busy=0, fault=0, state_o=0.
- Outputs are Moore, decoded from registered state. Output changes appear the clock edge after the qualifying sample_valid cycle (1-cycle latency).
- All compares are unsigned.
  - cool_exit = hi_th - hyst, saturating at 0.
  - heat_exit = lo_th + hyst, saturating at 2^W-1.
  - Computed in W+1 bits, then clamped.
- Samples are only evaluated when sample_valid=1. temp is ignored otherwise.
- IDLE:
  - valid && temp >= hi_th -> COOL.
  - valid && temp <= lo_th -> HEAT.
  - Otherwise stay.
  - Both entry conditions cannot hold unless fault, and fault blocks entry.
- HEAT (heat_out=1):
  - on_cnt increments (saturating) on each valid sample.
  - On the k-th valid sample after entry, with k >= MIN_ON and temp >= heat_exit -> LOCKOUT.
- COOL (cool_out=1):
  - Same as HEAT, with exit condition temp <= cool_exit.
- LOCKOUT (outputs 0):
  - lock_cnt loads LOCKOUT-1 on entry and decrements each clock.
  - At 0 -> IDLE, so exactly LOCKOUT cycles are spent in LOCKOUT.
  - Samples are ignored.
- HEAT never goes directly to COOL or back; all paths go through LOCKOUT.
- fault:
  - Registered copy of (lo_th >= hi_th), updated every clock.
  - While fault=1: HEAT/COOL go to LOCKOUT on the next clock, and IDLE entry is blocked.
  - LOCKOUT continues counting normally.
- enable=0:
  - Next clock goes to IDLE from any state, and counters clear.
  - Outputs are 0 from that edge.
  - fault still tracks.
- Threshold or hyst change mid-state takes effect on the next valid sample; it does not bypass MIN_ON.
- Async reset mid-LOCKOUT or mid-HEAT returns immediately to IDLE with outputs 0.

Optional Feature:
- Macro HYST_DEBOUNCE_EN.
- Defined:
  - IDLE entry requires two consecutive valid samples both meeting the same entry condition.
  - A one-bit pending flag plus the pending direction are kept.
  - A non-qualifying valid sample, enable=0 or fault clears the pending flag.
  - Entry occurs on the second sample.
- Undefined: a single qualifying sample enters, as above, and no pending logic is built.

Test Plan:
- Config for all scenarios unless stated: W=8, hi_th=90, lo_th=70, hyst=5, MIN_ON=2, LOCKOUT=8.
- Reset release, then valid temp=95 -> cool_out=1 next edge, state_o=2, heat_out=0.
- In COOL, send temp=80 then 84 -> stay COOL after the first sample (k=1 < MIN_ON). Second sample -> LOCKOUT, cool_out=0. Exactly 8 cycles later state_o=0.
- IDLE, temp=65 -> HEAT. Then temp=74, 76 -> stays HEAT on 74 (74 < heat_exit 75). 76 (k=2) -> LOCKOUT.
- Saturation: lo_th=250, hi_th=255, hyst=20, temp=250 -> HEAT. temp=255 twice -> exit (heat_exit clamps to 255). hi_th=10, hyst=20: cool_exit=0, exit only at temp=0.
- Fault: in HEAT, set lo_th=90, hi_th=90 -> fault=1 next edge, LOCKOUT following edge. temp=50 after lockout -> remains IDLE.
- enable dropped in COOL -> outputs 0 and state_o=0 next edge. With HYST_DEBOUNCE_EN: temp=95, 85, 95, 95 -> COOL entered only on the 4th sample.
